// File: rtl/piso_frame_serializer.sv
// Parallel-in serial-out framer: takes WIDTH-bit words over valid/ready and
// emits one bit per clk with frame strobes and an optional trailing parity bit.
module piso_frame_serializer #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int unsigned FL    = WIDTH + (PARITY_EN ? 1 : 0);
    localparam int unsigned CNT_W = $clog2(FL + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PAR
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_par;
    logic               r_serial;
    logic               r_bit_valid;
    logic               r_frame_start;
    logic               r_frame_end;
    logic               r_ready;

    logic               w_hs;
    logic               w_in_frame;
    logic               w_first_bit;
    logic [WIDTH-1:0]   w_load_shift;
    logic               w_next_bit;
    logic [WIDTH-1:0]   w_adv_shift;
    logic               w_parity;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_hs       = data_valid & r_ready;
    // A frame continues until its final bit is on the output.
    assign w_in_frame = (r_state != S_IDLE) && !r_frame_end;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // The shift register always presents the next bit at its "exit" end.
    assign w_first_bit  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
    assign w_load_shift = MSB_FIRST ? {data_in[WIDTH-2:0], 1'b0}
                                    : {1'b0, data_in[WIDTH-1:1]};
    assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_adv_shift  = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_shift[WIDTH-1:1]};
    assign w_parity     = PARITY_ODD ? ~(^data_in) : (^data_in);

    // Frame sequencer; r_cnt counts bits already placed on serial_out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_par         <= 1'b0;
            r_serial      <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_ready       <= 1'b0;
        end else if (w_hs) begin
            r_state       <= S_DATA;
            r_shift       <= w_load_shift;
            r_par         <= w_parity;
            r_cnt         <= CNT_W'(1);
            r_serial      <= w_first_bit;
            r_bit_valid   <= 1'b1;
            r_frame_start <= 1'b1;
            r_frame_end   <= 1'b0;
            r_ready       <= 1'b0;
        end else if (w_in_frame) begin
            if (r_cnt < CNT_W'(WIDTH)) begin
                r_state  <= S_DATA;
                r_serial <= w_next_bit;
                r_shift  <= w_adv_shift;
            end else begin
                r_state  <= S_PAR;
                r_serial <= r_par;
            end
            r_cnt         <= w_cnt_inc;
            r_bit_valid   <= 1'b1;
            r_frame_start <= 1'b0;
            r_frame_end   <= (w_cnt_inc == CNT_W'(FL));
            r_ready       <= (w_cnt_inc == CNT_W'(FL));
        end else begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_serial      <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_ready       <= 1'b1;
        end
    end

    assign data_ready  = r_ready;
    assign serial_out  = r_serial;
    assign bit_valid   = r_bit_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign busy        = r_bit_valid;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Self-checking bench: four serializer configurations against a frame-list
// model, plus hand-computed bit sequences for the directed cases.
module tb_piso_frame_serializer;

    localparam int unsigned NI = 4;
    // g0: MSB first, g1: even parity, g2: odd parity, g3: LSB first
    localparam bit [NI-1:0] C_MSB = 4'b0111;
    localparam bit [NI-1:0] C_PAR = 4'b0110;
    localparam bit [NI-1:0] C_ODD = 4'b0100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] dv;
    logic [3:0]    din [NI];
    logic [NI-1:0] dr, so, bv, fs, fe, by;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            piso_frame_serializer #(
                .WIDTH      (4),
                .MSB_FIRST  (C_MSB[g]),
                .PARITY_EN  (C_PAR[g]),
                .PARITY_ODD (C_ODD[g])
            ) u_dut (
                .clk         (clk),
                .reset_n     (rst_n),
                .data_in     (din[g]),
                .data_valid  (dv[g]),
                .data_ready  (dr[g]),
                .serial_out  (so[g]),
                .bit_valid   (bv[g]),
                .frame_start (fs[g]),
                .frame_end   (fe[g]),
                .busy        (by[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int            m_pos [NI];
    int            m_len [NI];
    logic          m_frm [NI][5];
    logic [NI-1:0] e_so, e_bv, e_fs, e_fe, e_dr;

    task automatic check(string name, int idx, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%b want=%b t=%0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NI; k++) begin
            m_pos[k] = 0;
            m_len[k] = 0;
        end
        e_so = '0; e_bv = '0; e_fs = '0; e_fe = '0; e_dr = '0;
    endtask

    // On a handshake the whole frame is expanded into a bit list, then one
    // entry is played out per clock; ready whenever nothing is left to play.
    task automatic model_step();
        logic [3:0] w;
        int         n;
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int k = 0; k < NI; k++) begin
            if (dv[k] && e_dr[k]) begin
                w = din[k];
                n = 0;
                for (int i = 0; i < 4; i++) begin
                    m_frm[k][n] = C_MSB[k] ? w[3-i] : w[i];
                    n++;
                end
                if (C_PAR[k]) begin
                    m_frm[k][n] = (^w) ^ C_ODD[k];
                    n++;
                end
                m_len[k] = n;
                m_pos[k] = 0;
            end
            if (m_pos[k] < m_len[k]) begin
                e_so[k] = m_frm[k][m_pos[k]];
                e_bv[k] = 1'b1;
                e_fs[k] = (m_pos[k] == 0);
                e_fe[k] = (m_pos[k] == m_len[k] - 1);
                m_pos[k]++;
            end else begin
                e_so[k] = 1'b0;
                e_bv[k] = 1'b0;
                e_fs[k] = 1'b0;
                e_fe[k] = 1'b0;
            end
            e_dr[k] = (m_pos[k] == m_len[k]);
        end
    endtask

    task automatic compare_step();
        for (int k = 0; k < NI; k++) begin
            check("data_ready",  k, dr[k], e_dr[k]);
            check("serial_out",  k, so[k], e_so[k]);
            check("bit_valid",   k, bv[k], e_bv[k]);
            check("frame_start", k, fs[k], e_fs[k]);
            check("frame_end",   k, fe[k], e_fe[k]);
            check("busy",        k, by[k], e_bv[k]);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first frame bit.
    task automatic start_word(int k, logic [3:0] w, bit keep_valid);
        int n;
        din[k] = w;
        dv[k]  = 1'b1;
        n = 0;
        while (!dr[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("handshake_wait", k, dr[k], 1'b1);
        @(negedge clk);
        if (!keep_valid) dv[k] = 1'b0;
    endtask

    // bits[n-1] is the first bit on the wire.
    task automatic expect_frame(int k, logic [4:0] bits, int n);
        for (int i = 0; i < n; i++) begin
            check("lit_bit",   k, so[k], bits[n-1-i]);
            check("lit_valid", k, bv[k], 1'b1);
            check("lit_start", k, fs[k], (i == 0));
            check("lit_end",   k, fe[k], (i == n - 1));
            @(negedge clk);
        end
        check("lit_idle_valid", k, bv[k], 1'b0);
        check("lit_idle_ready", k, dr[k], 1'b1);
    endtask

    logic [7:0] b2b_bits;
    logic [3:0] t5_bits;

    initial begin
        rst_n = 1'b0;
        dv    = '0;
        for (int k = 0; k < NI; k++) din[k] = 4'h0;
        model_clear();

        fork
            forever begin
                @(posedge clk or negedge rst_n);
                model_step();
            end
            forever begin
                @(negedge clk);
                compare_step();
            end
            begin
                repeat (5000) @(posedge clk);
                $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
                $fatal(1);
            end
        join_none

        // Reset release: ready rises on the first edge, line stays quiet
        repeat (3) @(negedge clk);
        check("rst_ready", 0, dr[0], 1'b0);
        check("rst_serial", 0, so[0], 1'b0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 0, dr[0], 1'b0);
        @(negedge clk);
        check("ready_after_edge", 0, dr[0], 1'b1);
        check("idle_valid", 0, bv[0], 1'b0);
        check("idle_serial", 0, so[0], 1'b0);

        // Single word, MSB first
        start_word(0, 4'b1011, 1'b0);
        expect_frame(0, 5'b01011, 4);

        // Back-to-back words with valid held high
        b2b_bits = 8'b1010_0101;
        din[0] = 4'hA;
        start_word(0, 4'hA, 1'b1);
        din[0] = 4'h5;
        for (int i = 0; i < 8; i++) begin
            check("b2b_bit",   0, so[0], b2b_bits[7-i]);
            check("b2b_valid", 0, bv[0], 1'b1);
            check("b2b_start", 0, fs[0], (i == 0 || i == 4));
            check("b2b_end",   0, fe[0], (i == 3 || i == 7));
            if (i == 4) dv[0] = 1'b0;
            @(negedge clk);
        end
        check("b2b_idle", 0, bv[0], 1'b0);

        // Parity variants and LSB-first ordering
        start_word(1, 4'b0111, 1'b0);
        expect_frame(1, 5'b01111, 5);
        start_word(2, 4'b0111, 1'b0);
        expect_frame(2, 5'b01110, 5);
        start_word(3, 4'b0001, 1'b0);
        expect_frame(3, 5'b01000, 4);

        // Valid and data toggling mid-frame must not be captured
        t5_bits = 4'b1001;
        start_word(0, 4'b1001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("ignore_bit",   0, so[0], t5_bits[3-i]);
            check("ignore_ready", 0, dr[0], (i == 3));
            if (i < 3) begin
                dv[0]  = 1'b1;
                din[0] = 4'($urandom);
            end else begin
                dv[0] = 1'b0;
            end
            @(negedge clk);
        end
        check("ignore_idle", 0, bv[0], 1'b0);

        // Asynchronous abort mid-frame, then a clean frame
        start_word(0, 4'b1100, 1'b0);
        @(negedge clk);
        check("abort_bit2", 0, so[0], 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_serial", 0, so[0], 1'b0);
        check("abort_valid",  0, bv[0], 1'b0);
        check("abort_ready",  0, dr[0], 1'b0);
        check("abort_busy",   0, by[0], 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_valid", 0, bv[0], 1'b0);
        start_word(0, 4'b0110, 1'b0);
        expect_frame(0, 5'b00110, 4);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
